// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS-style control sequencer with retired-instruction counter
// Define ILLEGAL_OP_TRAP_EN to park in HALT on an illegal opcode instead of skipping it.
module mc_control_fsm #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_ADDI  = 6'b001000,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic             w_illegal_set;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire)      r_retired <= r_retired + CNT_W'(1);
      if (w_illegal_set) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_retire      = 1'b0;
    w_illegal_set = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'd0;
    ALUOp         = 2'b00;
    PCSource      = 2'd0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        if (opcode == OP_LW || opcode == OP_SW) w_next = S_MEMADR;
        else if (opcode == OP_RTYPE)            w_next = S_EXEC;
        else if (opcode == OP_BEQ)              w_next = S_BRANCH;
        else if (opcode == OP_ADDI)             w_next = S_ADDIEX;
        else if (opcode == OP_J)                w_next = S_JUMP;
        else begin
          w_illegal_set = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_retire = mem_ready;
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        w_retire    = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_retire = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        w_retire = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: w_next = S_HALT;
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset aborts mid-instruction: no strobe may reach memory or the register file.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'b00;
      PCSource    = 2'd0;
    end
  end

  assign state   = r_state;
  assign retired = r_retired;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm with randomized instruction stream
// Honours ILLEGAL_OP_TRAP_EN to match the design build.
module tb_mc_control_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic [CW-1:0] retired;
  logic          illegal;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;
  logic [5:0] op_tab [0:5] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};

  typedef struct {
    int cyc; int irw; int pcw; int pcwc; int mr; int mw; int rw;
    int wbsel; int path; int ret; int ill;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_ret = 0;
  int   exp_ill = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] illegal_op();
    logic [5:0] op;
    do op = 6'($urandom);
    while (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b001000 || op == 6'b000100 || op == 6'b000010);
    return op;
  endfunction

  task automatic cyc(input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    repeat (2) begin
      @(negedge clk);
      check("rst_strobes", {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}, 0);
      check("rst_selects", {IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource}, 0);
      @(posedge clk);
      #1;
    end
    check("rst_state", state, 0);
    check("rst_retired", retired, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b0;
    exp_ret = 0;
    exp_ill = 0;
  endtask

  // Reference: per-instruction cycle budget, strobe totals and visited-state path.
  task automatic run_instr(input int kind, input int f, input int m);
    logic       mr_q[$];
    logic [5:0] op_q[$];
    logic [5:0] op;
    rec_t       e;
    op = (kind == K_ILL) ? illegal_op() : op_tab[kind];
    for (int i = 0; i < f; i++) begin mr_q.push_back(1'b0); op_q.push_back(6'($urandom)); end
    mr_q.push_back(1'b1); op_q.push_back(6'($urandom));
    case (kind)
      K_LW: begin
        repeat (2) begin mr_q.push_back(1'($urandom)); op_q.push_back(op); end
        for (int i = 0; i < m; i++) begin mr_q.push_back(1'b0); op_q.push_back(op); end
        mr_q.push_back(1'b1); op_q.push_back(op);
        mr_q.push_back(1'($urandom)); op_q.push_back(op);
      end
      K_SW: begin
        repeat (2) begin mr_q.push_back(1'($urandom)); op_q.push_back(op); end
        for (int i = 0; i < m; i++) begin mr_q.push_back(1'b0); op_q.push_back(op); end
        mr_q.push_back(1'b1); op_q.push_back(op);
      end
      K_R, K_ADDI: repeat (3) begin mr_q.push_back(1'($urandom)); op_q.push_back(op); end
      K_BEQ, K_J:  repeat (2) begin mr_q.push_back(1'($urandom)); op_q.push_back(op); end
      default:     begin mr_q.push_back(1'($urandom)); op_q.push_back(op); end
    endcase
    e.cyc   = mr_q.size();
    e.irw   = 1;
    e.pcw   = (kind == K_J) ? 2 : 1;
    e.pcwc  = (kind == K_BEQ) ? 1 : 0;
    e.mr    = f + 1 + ((kind == K_LW) ? m + 1 : 0);
    e.mw    = (kind == K_SW) ? m + 1 : 0;
    e.rw    = (kind == K_LW || kind == K_R || kind == K_ADDI) ? 1 : 0;
    e.wbsel = (kind == K_LW) ? 1 : (kind == K_R) ? 2 : 0;
    case (kind)
      K_LW:    e.path = 'h1234;
      K_SW:    e.path = 'h125;
      K_R:     e.path = 'h167;
      K_ADDI:  e.path = 'h19A;
      K_BEQ:   e.path = 'h18;
      K_J:     e.path = 'h1B;
      default: e.path = 'h1;
    endcase
    if (kind == K_ILL) exp_ill = 1;
    else               exp_ret = (exp_ret + 1) % (1 << CW);
    e.ret = exp_ret;
    e.ill = exp_ill;
    exp_q.push_back(e);
    foreach (mr_q[i]) cyc(mr_q[i], op_q[i]);
  endtask

  rec_t m_e;
  int   m_cyc, m_irw, m_pcw, m_pcwc, m_mr, m_mw, m_rw, m_wbsel, m_path;
  bit   m_have = 1'b0;
  logic [3:0] m_prev = 4'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_have && state == 4'd0 && m_prev != 4'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          check("cycles", m_cyc, m_e.cyc);
          check("path", m_path, m_e.path);
          check("irwrite_cnt", m_irw, m_e.irw);
          check("pcwrite_cnt", m_pcw, m_e.pcw);
          check("pcwritecond_cnt", m_pcwc, m_e.pcwc);
          check("memread_cnt", m_mr, m_e.mr);
          check("memwrite_cnt", m_mw, m_e.mw);
          check("regwrite_cnt", m_rw, m_e.rw);
          check("wb_select", m_wbsel, m_e.wbsel);
          check("retired", int'(retired), m_e.ret);
          check("illegal", int'(illegal), m_e.ill);
        end
        m_have = 1'b0;
      end
      if (!m_have) begin
        m_cyc = 0; m_irw = 0; m_pcw = 0; m_pcwc = 0; m_mr = 0;
        m_mw = 0; m_rw = 0; m_wbsel = 0; m_path = 0;
        m_have = 1'b1;
      end
      if (m_cyc == 0) m_path = int'(state);
      else if (state != m_prev) m_path = (m_path << 4) | int'(state);
      m_cyc++;
      m_irw  += int'(IRWrite);
      m_pcw  += int'(PCWrite);
      m_pcwc += int'(PCWriteCond);
      m_mr   += int'(MemRead);
      m_mw   += int'(MemWrite);
      m_rw   += int'(RegWrite);
      if (RegWrite) m_wbsel = int'({RegDst, MemtoReg});
      m_prev = state;
    end else begin
      m_have = 1'b0;
      m_prev = 4'd0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    @(posedge clk);
    #1;
    do_reset();
    mem_ready = 1'b1;
    opcode = 6'b000010;
    @(negedge clk);
    check("first_fetch", {MemRead, IRWrite, PCWrite}, 3'b111);
    @(posedge clk);
    #1;

    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 17; i++) run_instr(K_R, 0, 0);
    for (int k = K_LW; k <= K_J; k++) run_instr(k, 0, 0);
    run_instr(K_LW, 3, 2);
    for (int i = 0; i < 150; i++) begin
`ifdef ILLEGAL_OP_TRAP_EN
      kind = int'($urandom_range(0, 5));
`else
      kind = int'($urandom_range(0, 6));
`endif
      run_instr(kind, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    repeat (4) cyc(1'b0, 6'($urandom));
    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    do_reset();
    cyc(1'b1, 6'b101011);
    cyc(1'($urandom), 6'b101011);
    cyc(1'($urandom), 6'b101011);
    mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("memwr_wait_state", state, 5);
      check("memwr_wait_strobe", MemWrite, 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("abort_no_write", {MemWrite, RegWrite}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_state", state, 0);
    check("abort_retired", retired, 0);

    do_reset();
    cyc(1'b1, 6'b111111);
    cyc(1'b1, 6'b111111);
    check("ill_flag", illegal, 1);
    check("ill_retired", retired, 0);
`ifdef ILLEGAL_OP_TRAP_EN
    repeat (20) begin
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      @(negedge clk);
      check("halt_state", state, 12);
      check("halt_strobes", {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}, 0);
      @(posedge clk);
      #1;
    end
    do_reset();
`else
    check("ill_skip_state", state, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle control sequencer for the team's MIPS-style datapath, which has one shared instruction/data memory, an IR, and A/B/ALUOut/MDR latches. It decodes the 6-bit opcode and steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select/strobe and waits on a memory ready handshake. It also counts retired instructions for bring-up and debug.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  in  1  system clock, all state changes on posedge
rst  in  1  synchronous active-high reset
opcode  in  6  instruction[31:26] from IR
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero_flag
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  writeback data: 0=ALUOut, 1=MDR
RegDst  out  1  dest reg: 0=rt, 1=rd
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct decode (feeds ALUcontrol)
PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
state  out  4  current state encoding (debug)
retired  out  CNT_W  instructions completed since reset
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- On posedge clk with rst=1: state<=FETCH(0), retired<=0, illegal<=0. While rst=1, all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) read 0. All selects read 0.
- Outputs are a combinational decode of state and mem_ready (Moore, with mem gating). Any output not listed for a state is 0.
- State encodings: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 RWB7 BRANCH8 ADDIEX9 ADDIWB10 JUMP11 HALT12.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other -> FETCH; illegal<=1 and retired unchanged.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next: LW->MEMRD, SW->MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Then -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=10. Then -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=1. Then -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Then -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Then -> FETCH.
- JUMP: PCWrite=1, PCSource=2. Then -> FETCH.
- Retirement: retired increments by 1 on the final cycle of each legal instruction, i.e. the state transition back to FETCH from MEMWB, MEMWR (only on mem_ready), RWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied high:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each extra mem_ready=0 cycle adds one cycle in FETCH, MEMRD or MEMWR.
- opcode is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite is 0 outside FETCH.
- rst asserted in any state, including a memory wait, aborts the instruction: state=FETCH on the next edge, and no RegWrite/MemWrite strobe is issued in the reset cycle.
- Unused state codes 13-15 go to FETCH on the next edge.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: an illegal opcode in DECODE goes to HALT instead of FETCH, and illegal<=1.
  - HALT asserts no strobes and is left only by rst. state reads 12.
- Undefined: HALT is not built; illegal opcodes set illegal and return to FETCH (skip). State code 12 behaves as unused.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1 -> state=0, retired=0, illegal=0, all strobes 0 during reset; first cycle after release: MemRead=1, IRWrite=1, PCWrite=1.
- mem_ready=1, opcode sequence lw(100011), sw, R-type, addi, beq, j -> state paths 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-9-10, 0-1-8, 0-1-11; total 23 cycles; retired=6.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> lw takes 10 cycles; IRWrite high exactly 1 cycle; RegWrite+MemtoReg high exactly 1 cycle.
- rst pulsed during MEMWR wait (mem_ready=0) -> MemWrite never coincides with mem_ready=1; state=0 next edge; retired=0.
- opcode 6'b111111 -> illegal=1, retired unchanged; without ILLEGAL_OP_TRAP_EN returns to FETCH at cycle 3; with it, state=12 held for 20 cycles, no strobes, until rst.
- CNT_W=4, 17 R-type instructions -> retired wraps 15->0, reads 1 at end.
